// File: rtl/hr_beat_counter.sv
// Heartbeat pulse counter: synchronises the sensor comparator, rejects bounce with a
// refractory window, latches BPM at window end and restarts the timer on acknowledge.
module hr_beat_counter #(
  parameter int unsigned REFRACT_CYCLES = 12500000,
  parameter int unsigned BPM_MULT       = 10,
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned BPM_W          = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse_in,
  input  logic               window_done,
  input  logic               cpu_ack,
  output logic [COUNT_W-1:0] beat_count,
  output logic [BPM_W-1:0]   bpm,
  output logic               bpm_valid,
  output logic               timer_restart
);

  localparam int unsigned REF_W = (REFRACT_CYCLES > 2) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [REF_W-1:0]   REF_LOAD  = REF_W'(REFRACT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    COUNT    = 2'd0,
    WAIT_ACK = 2'd1,
    RESTART  = 2'd2
  } state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic [REF_W-1:0]   refract;
  logic               rise_c;
  logic               accept_c;
  logic [BPM_W-1:0]   bpm_next_c;

  assign rise_c     = s2 & ~s3;
  // A beat only counts while counting, outside refractory, and not on the latch cycle.
  assign accept_c   = rise_c && (refract == '0) && (state == COUNT) && !window_done;
  assign bpm_next_c = BPM_W'(beat_count) * BPM_W'(BPM_MULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      refract       <= '0;
      beat_count    <= '0;
      bpm           <= '0;
      bpm_valid     <= 1'b0;
      timer_restart <= 1'b0;
      state         <= COUNT;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
      if (refract != '0) refract <= refract - REF_W'(1);

      case (state)
        COUNT: begin
          if (window_done) begin
            bpm       <= bpm_next_c;
            bpm_valid <= 1'b1;
            state     <= WAIT_ACK;
          end else if (accept_c) begin
            refract <= REF_LOAD;
            if (beat_count != COUNT_MAX) beat_count <= beat_count + COUNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (cpu_ack) begin
            bpm_valid     <= 1'b0;
            timer_restart <= 1'b1;
            beat_count    <= '0;
            refract       <= '0;
            state         <= RESTART;
          end
        end
        RESTART: begin
          // Timer's time_is_up is still high here; it clears on this edge.
          timer_restart <= 1'b0;
          state         <= COUNT;
        end
        default: state <= COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_hr_beat_counter.sv
// Directed bench for hr_beat_counter with a short refractory period and a
// behavioural window timer that clears its flag when it sees timer_restart.
module tb_hr_beat_counter;

  localparam int unsigned REFRACT_CYCLES = 4;
  localparam int unsigned BPM_MULT       = 10;
  localparam int unsigned COUNT_W        = 8;
  localparam int unsigned BPM_W          = 12;

  logic               clk = 1'b0;
  logic               reset;
  logic               pulse_in;
  logic               window_done;
  logic               cpu_ack;
  logic [COUNT_W-1:0] beat_count;
  logic [BPM_W-1:0]   bpm;
  logic               bpm_valid;
  logic               timer_restart;

  logic tmr_fire;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   restarts;

  always #10 clk = ~clk;

  // Timer model: time_is_up sets on request, clears on the edge that samples cpu_is_ready.
  always_ff @(posedge clk) begin
    if (reset || timer_restart) window_done <= 1'b0;
    else if (tmr_fire)          window_done <= 1'b1;
  end

  hr_beat_counter #(
    .REFRACT_CYCLES(REFRACT_CYCLES),
    .BPM_MULT      (BPM_MULT),
    .COUNT_W       (COUNT_W),
    .BPM_W         (BPM_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .window_done  (window_done),
    .cpu_ack      (cpu_ack),
    .beat_count   (beat_count),
    .bpm          (bpm),
    .bpm_valid    (bpm_valid),
    .timer_restart(timer_restart)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    pulse_in = 1'b1;
    step(hi);
    pulse_in = 1'b0;
    step(lo);
  endtask

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    cpu_ack  = 1'b0;
    tmr_fire = 1'b0;

    // 1: reset with pulse_in toggling
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      step(1);
      check("rst_beat",    int'(beat_count),    0);
      check("rst_bpm",     int'(bpm),           0);
      check("rst_valid",   int'(bpm_valid),     0);
      check("rst_restart", int'(timer_restart), 0);
    end
    reset    = 1'b0;
    pulse_in = 1'b0;
    step(4);
    check("post_rst_beat", int'(beat_count), 0);

    // 2: five clean pulses then window end
    for (int i = 0; i < 5; i++) pulse(2, 8);
    check("clean_beat", int'(beat_count), 5);
    tmr_fire = 1'b1;
    step(1);
    tmr_fire = 1'b0;
    check("latch_not_yet", int'(bpm_valid), 0);
    step(1);
    check("latch_bpm",   int'(bpm),        50);
    check("latch_valid", int'(bpm_valid),  1);
    check("latch_beat",  int'(beat_count), 5);

    // 4: held acknowledge with window_done high through RESTART
    cpu_ack  = 1'b1;
    restarts = 0;
    step(1);
    restarts += int'(timer_restart);
    check("ack_restart_hi", int'(timer_restart), 1);
    check("ack_valid",      int'(bpm_valid),     0);
    check("ack_beat",       int'(beat_count),    0);
    check("ack_bpm",        int'(bpm),           50);
    check("ack_wd_in_rst",  int'(window_done),   1);
    step(1);
    restarts += int'(timer_restart);
    check("ack_restart_lo", int'(timer_restart), 0);
    check("ack_wd_cleared", int'(window_done),   0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      restarts += int'(timer_restart);
    end
    cpu_ack = 1'b0;
    check("ack_one_restart", restarts,        1);
    check("ack_no_relatch",  int'(bpm_valid), 0);
    check("ack_bpm_kept",    int'(bpm),       50);

    // 3: bounce, edges at t, t+2, t+4 -> t and t+4 accepted
    for (int i = 0; i < 6; i++) begin
      pulse_in = ~pulse_in;
      step(1);
    end
    pulse_in = 1'b0;
    step(8);
    check("bounce_beat", int'(beat_count), 2);
    pulse(1, 2);
    pulse(1, 8);
    check("refract_3_reject", int'(beat_count), 3);
    pulse(1, 3);
    pulse(1, 8);
    check("refract_4_accept", int'(beat_count), 5);
    pulse(2, 8);
    check("sixth_beat", int'(beat_count), 6);

    // edge and window_done on the same cycle: edge dropped
    pulse_in = 1'b1;
    step(1);
    tmr_fire = 1'b1;
    step(1);
    tmr_fire = 1'b0;
    pulse_in = 1'b0;
    step(1);
    check("coinc_bpm",   int'(bpm),        60);
    check("coinc_beat",  int'(beat_count), 6);
    check("coinc_valid", int'(bpm_valid),  1);

    // pulses in WAIT_ACK are ignored
    pulse(1, 5);
    pulse(1, 5);
    check("wait_frozen", int'(beat_count), 6);
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    check("ack2_restart", int'(timer_restart), 1);
    step(3);

    // 5: saturation
    for (int i = 0; i < 300; i++) pulse(1, 4);
    check("sat_beat", int'(beat_count), 255);
    tmr_fire = 1'b1;
    step(1);
    tmr_fire = 1'b0;
    step(1);
    check("sat_bpm",   int'(bpm),       2550);
    check("sat_valid", int'(bpm_valid), 1);

    // 6: reset and ack on the same cycle in WAIT_ACK
    reset   = 1'b1;
    cpu_ack = 1'b1;
    step(1);
    check("rstack_bpm",     int'(bpm),           0);
    check("rstack_valid",   int'(bpm_valid),     0);
    check("rstack_restart", int'(timer_restart), 0);
    check("rstack_beat",    int'(beat_count),    0);
    reset   = 1'b0;
    cpu_ack = 1'b0;
    step(1);
    check("rstack_restart2", int'(timer_restart), 0);
    pulse(2, 8);
    check("rstack_counting", int'(beat_count), 1);
    check("rstack_no_latch", int'(bpm_valid),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
